mc_cpu_param: RTL and testbench

//  Parametrised multi-cycle processor core: IF/ID/EX/MEM/WB FSM, configurable datapath width and

---
 rtl/mc_cpu_pkg.sv | 35 +++
 rtl/mc_cpu_param_regfile.sv | 38 +++
 rtl/mc_cpu_param.sv | 152 +++++++++++++++
 tb/tb_mc_cpu_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states and
// instruction-register field positions expressed as functions of RW.
package mc_cpu_pkg;

    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_SUB = 2'b01;
    localparam logic [1:0] OPC_LD  = 2'b10;
    localparam logic [1:0] OPC_STB = 2'b11;   // ST when imm=0, BNZ when imm=1

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Instruction layout, MSB first: {opc[1:0], imm, ra, rb, rd}; rd sits at bit 0.
    function automatic int rb_lsb(input int rw);
        return rw;
    endfunction

    function automatic int ra_lsb(input int rw);
        return 2 * rw;
    endfunction

    function automatic int imm_pos(input int rw);
        return 3 * rw;
    endfunction

    function automatic int opc_lsb(input int rw);
        return 3 * rw + 1;
    endfunction

endpackage

// File: rtl/mc_cpu_param_regfile.sv
// Register file: NREG x N bits, two combinational read ports, one
// synchronous write port, cleared asynchronously by reset_n.
module regfile_param #(
    parameter  int N    = 8,
    parameter  int NREG = 4,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [RW-1:0] raddr_a,
    input  logic [RW-1:0] raddr_b,
    output logic [N-1:0]  rdata_a,
    output logic [N-1:0]  rdata_b,
    input  logic          wen,
    input  logic [RW-1:0] waddr,
    input  logic [N-1:0]  wdata
);

    logic [N-1:0] regs [NREG];

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

    // Storage: cleared on reset, written on wen.
    // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the architectural state must be all-zero after reset, so this small
            // array is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/mc_cpu_param.sv
// Multi-cycle core: IF/ID/EX/MEM/WB sequencing, ADD/SUB/LD/ST/BNZ,
// ack-based load/store handshakes. All outputs are registered.
module mc_cpu_param
    import mc_cpu_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NREG = 4,
    localparam int RW   = $clog2(NREG),
    localparam int IW   = 3 + 3 * RW
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [N-1:0]  pc,
    input  logic [IW-1:0] instr_data,
    output logic [N-1:0]  ld_addr,
    output logic          ld_req,
    input  logic [N-1:0]  ld_data,
    input  logic          ld_ack,
    output logic [N-1:0]  st_addr,
    output logic [N-1:0]  st_data,
    output logic          st_en,
    input  logic          st_ack
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir;
    logic [N-1:0]  a_q, b_q, opb_q, res_q;
    logic [N-1:0]  rd_a, rd_b;

    // Instruction fields decoded from the latched instruction.
    logic [1:0]    opc;
    logic          imm;
    logic [RW-1:0] ra_f, rb_f, rd_f;
    logic [N-1:0]  imm_zext, br_off;

    assign opc      = ir[opc_lsb(RW) +: 2];
    assign imm      = ir[imm_pos(RW)];
    assign ra_f     = ir[ra_lsb(RW) +: RW];
    assign rb_f     = ir[rb_lsb(RW) +: RW];
    assign rd_f     = ir[RW-1:0];
    assign imm_zext = {{(N-RW){1'b0}}, rb_f};
    assign br_off   = {{(N-2*RW){ir[2*RW-1]}}, ir[2*RW-1:0]};

    // Control strobes derived from the current state.
    logic fetch, decode, exec, ld_done, st_done, rf_we;

    regfile_param #(.N(N), .NREG(NREG)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .raddr_a (ra_f),
        .raddr_b (rb_f),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .wen     (rf_we),
        .waddr   (rd_f),
        .wdata   (res_q)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IF;
        else          state_q <= state_d;
    end

    // Next-state logic; unused encodings fall back to IF.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: state_d = S_EX;
            S_EX: begin
                case (opc)
                    OPC_ADD, OPC_SUB: state_d = S_WB;
                    OPC_LD:           state_d = S_MEM;
                    OPC_STB:          state_d = imm ? S_IF : S_MEM;
                endcase
            end
            S_MEM: begin
                if (opc == OPC_LD) state_d = ld_ack ? S_WB : S_MEM;
                else               state_d = st_ack ? S_IF : S_MEM;
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Per-state control strobes; acks only count in MEM and for the matching access type.
    always_comb begin
        fetch   = (state_q == S_IF);
        decode  = (state_q == S_ID);
        exec    = (state_q == S_EX);
        ld_done = (state_q == S_MEM) && (opc == OPC_LD) && ld_ack;
        st_done = (state_q == S_MEM) && (opc != OPC_LD) && st_ack;
        rf_we   = (state_q == S_WB);
    end

    // Datapath and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            ld_addr <= '0;
            ld_req  <= 1'b0;
            st_addr <= '0;
            st_data <= '0;
            st_en   <= 1'b0;
        end else begin
            if (fetch) begin
                ir <= instr_data;
                pc <= pc + N'(1);
            end
            if (decode) begin
                a_q   <= rd_a;
                b_q   <= rd_b;
                opb_q <= imm ? imm_zext : rd_b;
            end
            if (exec) begin
                case (opc)
                    OPC_ADD: res_q <= a_q + opb_q;
                    OPC_SUB: res_q <= a_q - opb_q;
                    OPC_LD: begin
                        ld_addr <= a_q + opb_q;
                        ld_req  <= 1'b1;
                    end
                    OPC_STB: begin
                        if (!imm) begin
                            st_addr <= a_q;
                            st_data <= b_q;
                            st_en   <= 1'b1;
                        end else if (a_q != '0) begin
                            // pc already points past the branch.
                            pc <= pc + br_off;
                        end
                    end
                endcase
            end
            if (ld_done) begin
                res_q  <= ld_data;
                ld_req <= 1'b0;
            end
            if (st_done) begin
                st_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mc_cpu_param.sv
// Directed bench for mc_cpu_param at N=8, NREG=4. Register contents are
// loaded through LD and observed through ST; pc is checked after branches.
module tb_mc_cpu_param;
    import mc_cpu_pkg::*;

    localparam int N    = 8;
    localparam int NREG = 4;
    localparam int IW   = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  pc, ld_addr, ld_data, st_addr, st_data;
    logic [IW-1:0] instr_data;
    logic          ld_req, ld_ack, st_en, st_ack;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] model [NREG];

    always #5 clk = ~clk;

    mc_cpu_param #(.N(N), .NREG(NREG)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc         (pc),
        .instr_data (instr_data),
        .ld_addr    (ld_addr),
        .ld_req     (ld_req),
        .ld_data    (ld_data),
        .ld_ack     (ld_ack),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_en      (st_en),
        .st_ack     (st_ack)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] enc(input logic [1:0] opc, input logic imm,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic [1:0] rd);
        return {opc, imm, ra, rb, rd};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All tasks start and end at a negedge inside an IF cycle.
    task automatic exec_alu(input logic [8:0] ins);
        instr_data = ins;
        tick(4);
    endtask

    task automatic exec_ld(input logic [8:0] ins, input int waits, input logic [7:0] data,
                           input logic [7:0] exp_addr, input string tag);
        instr_data = ins;
        tick(3);
        for (int i = 0; i <= waits; i++) begin
            check({tag, " ld_req held"}, ld_req, 1'b1);
            check({tag, " ld_addr"}, ld_addr, exp_addr);
            if (i < waits) tick(1);
        end
        ld_data = data;
        ld_ack  = 1'b1;
        tick(1);
        ld_ack  = 1'b0;
        check({tag, " ld_req drop"}, ld_req, 1'b0);
        tick(1);
    endtask

    // waits>0 cycles present a wrong-type ack (ld_ack) that must be ignored.
    task automatic exec_st(input logic [8:0] ins, input int waits, input logic [7:0] exp_addr,
                           input logic [7:0] exp_data, input string tag);
        instr_data = ins;
        tick(3);
        check({tag, " st_en"}, st_en, 1'b1);
        check({tag, " st_addr"}, st_addr, exp_addr);
        check({tag, " st_data"}, st_data, exp_data);
        for (int i = 0; i < waits; i++) begin
            ld_ack = 1'b1;
            tick(1);
            ld_ack = 1'b0;
            check({tag, " st_en held"}, st_en, 1'b1);
        end
        st_ack = 1'b1;
        tick(1);
        st_ack = 1'b0;
        check({tag, " st_en drop"}, st_en, 1'b0);
    endtask

    task automatic exec_bnz(input logic [8:0] ins, input logic [7:0] exp_pc, input string tag);
        instr_data = ins;
        tick(3);
        check(tag, pc, exp_pc);
    endtask

    task automatic set_reg(input logic [1:0] k, input logic [7:0] v);
        exec_ld(enc(OPC_LD, 1'b1, k, 2'd0, k), 0, v, model[k], "set_reg");
        model[k] = v;
    endtask

    task automatic read_reg(input logic [1:0] k, input logic [7:0] exp, input string tag);
        exec_st(enc(OPC_STB, 1'b0, k, k, 2'd0), 0, exp, exp, tag);
    endtask

    task automatic do_reset();
        ld_ack  = 1'b0;
        st_ack  = 1'b0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        instr_data = '0;
        ld_data    = '0;
        ld_ack     = 1'b0;
        st_ack     = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        #1;
        check("rst pc", pc, 8'h00);
        check("rst ld_req", ld_req, 1'b0);
        check("rst st_en", st_en, 1'b0);
        check("rst ld_addr", ld_addr, 8'h00);
        check("rst st_addr", st_addr, 8'h00);
        check("rst st_data", st_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: reset while a load waits for its ack.
        instr_data = enc(OPC_LD, 1'b1, 2'd0, 2'd1, 2'd0);
        tick(3);
        check("mid-ld ld_req", ld_req, 1'b1);
        check("mid-ld pc", pc, 8'h01);
        reset_n = 1'b0;
        #1;
        check("async rst pc", pc, 8'h00);
        check("async rst ld_req", ld_req, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        exec_alu(enc(OPC_ADD, 1'b0, 2'd0, 2'd0, 2'd3));
        check("fetch after rst pc", pc, 8'h01);

        // 2: ADD immediate; stray acks outside MEM are ignored.
        set_reg(2'd1, 8'h05);
        ld_ack = 1'b1;
        st_ack = 1'b1;
        exec_alu(enc(OPC_ADD, 1'b1, 2'd1, 2'd3, 2'd2));
        ld_ack = 1'b0;
        st_ack = 1'b0;
        model[2] = 8'h08;
        check("add pc", pc, 8'h03);
        read_reg(2'd2, 8'h08, "add R2");

        // 3: SUB wraps below zero, rd aliases ra.
        set_reg(2'd0, 8'h00);
        set_reg(2'd1, 8'h01);
        exec_alu(enc(OPC_SUB, 1'b0, 2'd0, 2'd1, 2'd0));
        model[0] = 8'hFF;
        read_reg(2'd0, 8'hFF, "sub R0");

        // 4: LD with three wait states.
        set_reg(2'd1, 8'h10);
        exec_ld(enc(OPC_LD, 1'b1, 2'd1, 2'd2, 2'd3), 3, 8'hA5, 8'h12, "ld3w");
        model[3] = 8'hA5;
        read_reg(2'd3, 8'hA5, "ld R3");

        // 5: ST acked in first MEM cycle, then ST with a wrong-type ack first.
        set_reg(2'd0, 8'h20);
        set_reg(2'd1, 8'h7E);
        exec_st(enc(OPC_STB, 1'b0, 2'd0, 2'd1, 2'd0), 0, 8'h20, 8'h7E, "st0w");
        exec_st(enc(OPC_STB, 1'b0, 2'd1, 2'd0, 2'd0), 1, 8'h7E, 8'h20, "st wrong ack");

        // 6: BNZ at pc=5, offset -2: taken -> 4, not taken -> 6.
        do_reset();
        set_reg(2'd1, 8'h01);
        for (int i = 0; i < 4; i++) exec_alu(enc(OPC_ADD, 1'b0, 2'd0, 2'd0, 2'd3));
        check("pre-bnz pc", pc, 8'h05);
        exec_bnz(enc(OPC_STB, 1'b1, 2'd1, 2'b11, 2'b10), 8'h04, "bnz taken");
        exec_alu(enc(OPC_ADD, 1'b0, 2'd0, 2'd0, 2'd3));
        exec_bnz(enc(OPC_STB, 1'b1, 2'd0, 2'b11, 2'b10), 8'h06, "bnz not taken");

        // pc wrap: branch back from pc=1 by -3 to 0xFF, then fall through to 0x00.
        do_reset();
        set_reg(2'd1, 8'h01);
        exec_bnz(enc(OPC_STB, 1'b1, 2'd1, 2'b11, 2'b01), 8'hFF, "bnz back to FF");
        exec_bnz(enc(OPC_STB, 1'b1, 2'd0, 2'b00, 2'b00), 8'h00, "pc wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
